// File: rtl/disp_scan8_pkg.sv
// disp_scan8_pkg: shared display definitions (disp_defs) for the 8-digit scanner.
// Provides the blank-level constants, the scan FSM state encoding and the
// active-low hex-to-7-segment table ({g,f,e,d,c,b,a}) indexed by nibble value.
package disp_scan8_pkg;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;
    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;
    // Entry [n] is the pattern for nibble n (listed F down to 0).
    localparam logic [15:0][6:0] HEX7 = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/disp_scan8_seg7_hex_dec.sv
// seg7_hex_dec: combinational 4-bit to active-low 7-segment decoder.
// Ports: nib_i - nibble to display; seg_o - {g,f,e,d,c,b,a}, active-low.
module seg7_hex_dec
    import disp_scan8_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX7[nib_i];
endmodule

// File: rtl/disp_scan8.sv
// disp_scan8: time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Ports: clk, rst_n (async active-low); data (8 nibbles, nibble i on digit i),
// dp_in (1 = point lit), blank_mask (1 = digit dark); sel (digit index),
// an (active-low one-hot anodes), seg/dp (active-low), frame_done (pulse after digit 7).
// Optional macro DISP_LZ_SUPPRESS_EN: blank digits above the most-significant
// nonzero nibble of the snapshot (digit 0 always shown).
module disp_scan8
    import disp_scan8_pkg::*;
#(
    parameter int CLK_DIV     = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_mask,
    output logic [2:0]  sel,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DEAD = PW'(DEAD_CYCLES);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    sel_q;
    state_e        state_q, state_d;
    logic          load_pend_q;
    logic [31:0]   data_snap_q;
    logic [7:0]    dp_snap_q, bm_snap_q, bm_eff;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d, dec_seg;
    logic          dp_q, dp_d;
    logic          tick, load, blank;

    assign tick    = presc_q == LAST;
    // Snapshot once right after reset and at every frame boundary.
    assign load    = load_pend_q | (tick & (sel_q == 3'd7));
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    // The slot is blanked while the prescaler is still inside the dead window.
    assign state_d = (presc_d >= DEAD) ? SHOW : BLANK;

`ifdef DISP_LZ_SUPPRESS_EN
    logic [7:0] lz_q, lz_d;
    // Digit i is a leading zero when every nibble from i upward is zero.
    always_comb begin
        lz_d = '0;
        for (int i = 1; i < 8; i++) lz_d[i] = ~|(data >> (4 * i));
    end
    assign bm_eff = bm_snap_q | lz_q;
`else
    assign bm_eff = bm_snap_q;
`endif

    seg7_hex_dec u_dec (
        .nib_i (data_snap_q[{sel_q, 2'b00} +: 4]),
        .seg_o (dec_seg)
    );

    assign blank = (state_q == BLANK) | bm_eff[sel_q];
    assign an_d  = blank ? AN_OFF : ~(8'b1 << sel_q);
    assign seg_d = blank ? SEG_OFF : dec_seg;
    assign dp_d  = blank | ~dp_snap_q[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            sel_q       <= '0;
            state_q     <= BLANK;
            load_pend_q <= 1'b1;
            data_snap_q <= '0;
            dp_snap_q   <= '0;
            bm_snap_q   <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
`ifdef DISP_LZ_SUPPRESS_EN
            lz_q        <= '0;
`endif
        end else begin
            presc_q     <= presc_d;
            sel_q       <= tick ? sel_q + 3'd1 : sel_q;
            state_q     <= state_d;
            load_pend_q <= 1'b0;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            if (load) begin
                data_snap_q <= data;
                dp_snap_q   <= dp_in;
                bm_snap_q   <= blank_mask;
`ifdef DISP_LZ_SUPPRESS_EN
                lz_q        <= lz_d;
`endif
            end
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = tick & (sel_q == 3'd7);
endmodule

// File: tb/tb_disp_scan8.sv
// tb_disp_scan8: scoreboard bench for disp_scan8 with CLK_DIV=4, DEAD_CYCLES=1.
module tb_disp_scan8;
    localparam int CD = 4;
    localparam int DC = 1;
    localparam int FR = 8 * CD;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] sel;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [7:0]  dp_in, blank_mask;
    logic [2:0]  sel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done;

    logic [6:0]  hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    exp_t        sb [$];
    logic [31:0] snap_data;
    logic [7:0]  snap_dp, snap_bm;
    int          k;
    int          fd_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    disp_scan8 #(.CLK_DIV(CD), .DEAD_CYCLES(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Expected output after the next edge reflects the state of the current
    // cycle k (k = clocks since reset release); snapshots happen on edge 1
    // and on every frame boundary edge.
    task automatic step();
        exp_t       e;
        int         s;
        logic       blk;
        logic [7:0] lz;
        s  = (k / CD) % 8;
        lz = '0;
`ifdef DISP_LZ_SUPPRESS_EN
        for (int i = 1; i < 8; i++) lz[i] = (snap_data >> (4 * i)) == 32'd0;
`endif
        blk    = ((k % CD) < DC) || snap_bm[s] || lz[s];
        e.an   = blk ? 8'hFF : ~(8'h01 << s);
        e.seg  = blk ? 7'h7F : hex[snap_data[4*s +: 4]];
        e.dp   = blk ? 1'b1 : ~snap_dp[s];
        e.sel  = 3'(((k + 1) / CD) % 8);
        e.fd   = ((k + 1) % FR) == FR - 1;
        sb.push_back(e);
        if (k == 0 || (k + 1) % FR == 0) begin
            snap_data = data;
            snap_dp   = dp_in;
            snap_bm   = blank_mask;
        end
        @(posedge clk);
        #1;
        k++;
        e = sb.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        if (frame_done) fd_cnt++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"}, 32'(an), 32'hFF);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_dp"}, 32'(dp), 32'd1);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        k          = 0;
        fd_cnt     = 0;
        snap_data  = '0;
        snap_dp    = '0;
        snap_bm    = '0;
        rst_n      = 1'b1;
        data       = 32'h89ABCDEF;
        dp_in      = 8'h00;
        blank_mask = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (2 * FR) step();
        chk("fd_count", 32'(fd_cnt), 32'd2);
        repeat (3 * CD) step();
        data = 32'h00000001;
        repeat (5 * CD + FR) step();
        dp_in      = 8'h01;
        blank_mask = 8'h0A;
        repeat (2 * FR) step();
        while ((k / CD) % 8 != 5) step();
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1;
        chk_reset("rst_hold");
        rst_n = 1'b1;
        k     = 0;
        data  = 32'h89ABCDEF;
        repeat (FR + 8) step();
`ifdef DISP_LZ_SUPPRESS_EN
        blank_mask = 8'h00;
        data       = 32'h00000120;
        repeat (2 * FR) step();
        data = 32'h00000000;
        repeat (2 * FR) step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
